rx_frame_fifo: RTL

- Receive-side byte buffer directly downstream of the serial frame receiver.
- Captures each received byte and its parity-error flag when the receiver signals frame-ready.
- Holds captured bytes in a first-word-fall-through FIFO for a consumer that reads at its own pace.
- Tracks overflow and parity-error events in saturating counters.

---
 rtl/rx_frame_fifo_if.sv | 29 ++
 rtl/rx_frame_fifo.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rx_frame_fifo_if.sv
// Capture, read and status signals between the frame receiver, rx_frame_fifo and its consumer.
// The slave modport is the FIFO side; the master modport is the receiver/consumer side.
interface rx_frame_fifo_if #(
    parameter int AW = 3
) ();
    logic          in_rdy;
    logic [7:0]    in_data;
    logic          in_per;
    logic          rd_en;
    logic          clr_stat;
    logic [7:0]    rd_data;
    logic          rd_per;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          ovf;
    logic [7:0]    ovf_cnt;
    logic [7:0]    per_cnt;

    modport master (
        output in_rdy, in_data, in_per, rd_en, clr_stat,
        input  rd_data, rd_per, empty, full, count, ovf, ovf_cnt, per_cnt
    );

    modport slave (
        input  in_rdy, in_data, in_per, rd_en, clr_stat,
        output rd_data, rd_per, empty, full, count, ovf, ovf_cnt, per_cnt
    );
endinterface

// File: rtl/rx_frame_fifo.sv
// Receive-side FWFT byte FIFO with frame-edge capture and saturating overflow/parity counters.
// Define RX_FIFO_PARITY_DROP_EN to discard parity-errored frames instead of storing them.
module rx_frame_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    rx_frame_fifo_if.slave bus
);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

`ifdef RX_FIFO_PARITY_DROP_EN
    localparam int EW = 8;
`else
    localparam int EW = 9;
`endif

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rdy_q, rdy_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
    logic [7:0]    per_cnt_q, per_cnt_d;

    logic          fe, pop, push, drop, per_ev, storable;
    logic          is_empty, is_full;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] head;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_COUNT);
    assign fe       = bus.in_rdy & ~rdy_q;
    assign pop      = bus.rd_en & ~is_empty;
    assign per_ev   = fe & bus.in_per;

`ifdef RX_FIFO_PARITY_DROP_EN
    assign storable = fe & ~bus.in_per;
    assign entry_in = bus.in_data;
`else
    assign storable = fe;
    assign entry_in = {bus.in_per, bus.in_data};
`endif

    // A full FIFO still accepts a frame when the consumer pops in the same cycle.
    assign push = storable & (~is_full | pop);
    assign drop = storable & is_full & ~pop;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry_in;
        end
    end

    always_comb begin
        rdy_d    = bus.in_rdy;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end

        // A clear coinciding with a new event restarts the statistics from that event.
        if (bus.clr_stat) begin
            ovf_d     = drop;
            ovf_cnt_d = drop ? 8'd1 : 8'd0;
            per_cnt_d = per_ev ? 8'd1 : 8'd0;
        end else begin
            ovf_d     = ovf_q | drop;
            ovf_cnt_d = (drop && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
            per_cnt_d = (per_ev && per_cnt_q != 8'hFF) ? per_cnt_q + 8'd1 : per_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rdy_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
            per_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rdy_q     <= rdy_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
            per_cnt_q <= per_cnt_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign bus.rd_data = is_empty ? 8'h00 : head[7:0];

`ifdef RX_FIFO_PARITY_DROP_EN
    assign bus.rd_per  = 1'b0;
`else
    assign bus.rd_per  = ~is_empty & head[8];
`endif

    assign bus.empty   = is_empty;
    assign bus.full    = is_full;
    assign bus.count   = count_q;
    assign bus.ovf     = ovf_q;
    assign bus.ovf_cnt = ovf_cnt_q;
    assign bus.per_cnt = per_cnt_q;
endmodule
